// File: rtl/fpga_robots_game_blinker.sv
// fpga_robots_game_blinker
//   Multi-channel LED pattern sequencer. A shared prescaler produces step
//   ticks. On each tick every channel either rotates its pattern (LOOP) or
//   plays it out once (ONESHOT) before going dark.
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     tick_div             prescaler terminal count (period = tick_div+1)
//     resync               clear prescaler, suppress this cycle's step
//     cfg_wen/ch/mode/pat  channel configuration write
//     step                 one-cycle pulse per step tick
//     busy[i]              channel i is playing a one-shot
//     led[i]               LED drive, 1 = lit

// Per-channel sequencer: mode/pattern/count state plus registered LED.
module fpga_robots_game_blinker_ch #(
   parameter int PLEN = 16,
   parameter int CNTW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            step_evt,
   input  logic            wen,
   input  logic [1:0]      wmode,
   input  logic [PLEN-1:0] wpat,
   output logic            led,
   output logic            busy
);
   localparam logic [1:0] M_OFF     = 2'd0;
   localparam logic [1:0] M_LOOP    = 2'd1;
   localparam logic [1:0] M_ONESHOT = 2'd2;
   localparam logic [1:0] M_ON      = 2'd3;

   logic [1:0]      mode, mode_nx;
   logic [PLEN-1:0] pat, pat_nx;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic            led_nx;

   // State register; reset value 17 gives the legacy double blink.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode <= M_LOOP;
         pat  <= PLEN'(17);
         cnt  <= '0;
      end else begin
         mode <= mode_nx;
         pat  <= pat_nx;
         cnt  <= cnt_nx;
      end
   end

   // Next state: a config write wins over the step update, so a freshly
   // written pattern always starts unrotated.
   always_comb begin
      mode_nx = mode;
      pat_nx  = pat;
      cnt_nx  = cnt;
      if (wen) begin
         mode_nx = wmode;
         pat_nx  = wpat;
         cnt_nx  = '0;
      end else if (step_evt) begin
         case (mode)
            M_LOOP: pat_nx = {pat[0], pat[PLEN-1:1]};
            M_ONESHOT: begin
               pat_nx = {1'b0, pat[PLEN-1:1]};
               if (cnt == CNTW'(PLEN-1)) begin
                  mode_nx = M_OFF;
                  cnt_nx  = '0;
               end else begin
                  cnt_nx = cnt + CNTW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: LED is registered from current state, busy is straight decode.
   always_comb begin
      led_nx = 1'b0;
      case (mode)
         M_ON:              led_nx = 1'b1;
         M_LOOP, M_ONESHOT: led_nx = pat[0];
         default:           led_nx = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) led <= 1'b0;
      else        led <= led_nx;
   end

   assign busy = (mode == M_ONESHOT);
endmodule

module fpga_robots_game_blinker #(
   parameter int NCH  = 2,
   parameter int PLEN = 16,
   parameter int DIVW = 22,
   parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DIVW-1:0] tick_div,
   input  logic            resync,
   input  logic            cfg_wen,
   input  logic [CHW-1:0]  cfg_ch,
   input  logic [1:0]      cfg_mode,
   input  logic [PLEN-1:0] cfg_pat,
   output logic            step,
   output logic [NCH-1:0]  busy,
   output logic [NCH-1:0]  led
);
   localparam int CNTW = $clog2(PLEN + 1);

   logic [DIVW-1:0] pre;
   logic            step_evt;

   // >= (not ==) so lowering tick_div below the running count ends the
   // period immediately instead of wrapping through 2^DIVW.
   assign step_evt = !resync && (pre >= tick_div);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre  <= '0;
         step <= 1'b0;
      end else begin
         step <= step_evt;
         if (resync || step_evt) pre <= '0;
         else                    pre <= pre + DIVW'(1);
      end
   end

   // Out-of-range cfg_ch matches no instance, so such writes fall away.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      fpga_robots_game_blinker_ch #(
         .PLEN (PLEN),
         .CNTW (CNTW)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .step_evt (step_evt),
         .wen      (cfg_wen && (cfg_ch == CHW'(gi))),
         .wmode    (cfg_mode),
         .wpat     (cfg_pat),
         .led      (led[gi]),
         .busy     (busy[gi])
      );
   end
endmodule

// File: tb/tb_fpga_robots_game_blinker.sv
module tb_fpga_robots_game_blinker;
   localparam int NCH  = 3;
   localparam int PLEN = 16;
   localparam int DIVW = 8;
   localparam int CHW  = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [DIVW-1:0] tick_div;
   logic            resync;
   logic            cfg_wen;
   logic [CHW-1:0]  cfg_ch;
   logic [1:0]      cfg_mode;
   logic [PLEN-1:0] cfg_pat;
   logic            step;
   logic [NCH-1:0]  busy;
   logic [NCH-1:0]  led;

   always #5 clk = ~clk;

   fpga_robots_game_blinker #(.NCH(NCH), .PLEN(PLEN), .DIVW(DIVW)) dut (
      .clk(clk), .rst_n(rst_n), .tick_div(tick_div), .resync(resync),
      .cfg_wen(cfg_wen), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_pat(cfg_pat),
      .step(step), .busy(busy), .led(led)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: each channel remembers the pattern as written and how
   // many steps it has played; the lit bit is looked up by position.
   int              m_pre;
   bit              m_step;
   int              m_mode [NCH];
   logic [PLEN-1:0] m_base [NCH];
   int              m_pos  [NCH];
   logic [NCH-1:0]  m_led;

   function automatic logic m_ledval(input int i);
      case (m_mode[i])
         1:       return m_base[i][m_pos[i] % PLEN];
         2:       return m_base[i][m_pos[i]];
         3:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [NCH-1:0] m_busy();
      logic [NCH-1:0] b;
      for (int i = 0; i < NCH; i++) b[i] = (m_mode[i] == 2);
      return b;
   endfunction

   task automatic model_edge();
      bit evt;
      if (!rst_n) begin
         m_pre = 0; m_step = 0; m_led = '0;
         for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 1; m_base[i] = 16'd17; m_pos[i] = 0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) m_led[i] = m_ledval(i);
         evt    = !resync && (m_pre >= int'(tick_div));
         m_pre  = (resync || evt) ? 0 : m_pre + 1;
         m_step = evt;
         for (int i = 0; i < NCH; i++) begin
            if (cfg_wen && int'(cfg_ch) == i) begin
               m_mode[i] = int'(cfg_mode); m_base[i] = cfg_pat; m_pos[i] = 0;
            end else if (evt && m_mode[i] == 1) begin
               m_pos[i] = (m_pos[i] + 1) % PLEN;
            end else if (evt && m_mode[i] == 2) begin
               m_pos[i]++;
               if (m_pos[i] == PLEN) begin
                  m_mode[i] = 0; m_pos[i] = 0;
               end
            end
         end
      end
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("model_step", 32'(step), 32'(m_step));
      chk("model_busy", 32'(busy), 32'(m_busy()));
      chk("model_led",  32'(led),  32'(m_led));
   endtask

   task automatic wr(input int ch, input int mode, input logic [PLEN-1:0] pat);
      cfg_ch = CHW'(ch); cfg_mode = 2'(mode); cfg_pat = pat; cfg_wen = 1'b1;
      tick();
      cfg_wen = 1'b0;
   endtask

   typedef struct {
      int              ch;
      int              mode;
      logic [PLEN-1:0] pat;
      logic [NCH-1:0]  exp_led;
      logic [NCH-1:0]  exp_busy;
   } vec_t;

   vec_t            tbl [8];
   logic [PLEN-1:0] p17;
   int              cnt;
   int              guard;

   initial begin
      tbl[0] = '{2, 3, 16'h0000, 3'b111, 3'b000};
      tbl[1] = '{2, 0, 16'hFFFF, 3'b011, 3'b000};
      tbl[2] = '{1, 2, 16'h0004, 3'b001, 3'b010};
      tbl[3] = '{3, 0, 16'h0000, 3'b001, 3'b010};
      tbl[4] = '{0, 2, 16'h0001, 3'b001, 3'b011};
      tbl[5] = '{1, 1, 16'h0003, 3'b011, 3'b001};
      tbl[6] = '{0, 0, 16'h0001, 3'b010, 3'b000};
      tbl[7] = '{2, 1, 16'h0002, 3'b010, 3'b000};
      p17 = 16'd17;

      rst_n = 1'b0; tick_div = 8'd3; resync = 1'b0;
      cfg_wen = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_pat = '0;
      @(negedge clk);

      // Reset held three cycles, then step cadence and legacy blink on ch0.
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_step", 32'(step), 0);
         chk("rst_led",  32'(led),  0);
         chk("rst_busy", 32'(busy), 0);
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         chk("cadence_step", 32'(step), 32'(c % 4 == 0));
         chk("blink_led0",   32'(led[0]), 32'(p17[((c - 1) / 4) % 16]));
      end

      // Mode table with steps suppressed by resync.
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      resync = 1'b1;
      tick();
      chk("tbl_init_led", 32'(led), 32'(3'b111));
      for (int v = 0; v < 8; v++) begin
         wr(tbl[v].ch, tbl[v].mode, tbl[v].pat);
         tick();
         chk("tbl_led",  32'(led),  32'(tbl[v].exp_led));
         chk("tbl_busy", 32'(busy), 32'(tbl[v].exp_busy));
      end
      tick();
      chk("tbl_led_hold", 32'(led), 32'(tbl[7].exp_led));
      resync = 1'b0;

      // Write colliding with a step loads unrotated.
      tick_div = 8'd3;
      resync = 1'b1; tick(); resync = 1'b0;
      repeat (3) tick();
      wr(0, 1, 16'h8001);
      chk("coll_step", 32'(step), 1);
      tick();
      chk("coll_led_w1", 32'(led[0]), 1);
      repeat (3) tick();
      chk("coll_led_w4", 32'(led[0]), 1);
      tick();
      chk("coll_led_w5", 32'(led[0]), 0);

      // One-shot on ch1 plays exactly PLEN steps then stays dark.
      wr(1, 2, 16'h0005);
      chk("os_busy", 32'(busy[1]), 1);
      cnt = 0; guard = 0;
      while (busy[1] && guard < 100) begin
         tick();
         if (step) cnt++;
         guard++;
      end
      chk("os_timeout", 32'(guard < 100), 1);
      chk("os_steps",   32'(cnt), 16);
      repeat (8) tick();
      chk("os_dark", 32'(led[1]), 0);

      // Lowering tick_div below the running count fires at once.
      tick_div = 8'd100;
      resync = 1'b1; tick(); resync = 1'b0;
      repeat (50) tick();
      tick_div = 8'd2;
      tick();
      chk("div_drop_step", 32'(step), 1);
      resync = 1'b1; tick(); resync = 1'b0;
      chk("resync_s0", 32'(step), 0);
      tick(); chk("resync_s1", 32'(step), 0);
      tick(); chk("resync_s2", 32'(step), 0);
      tick(); chk("resync_s3", 32'(step), 1);

      // tick_div = 0 steps every cycle.
      tick_div = 8'd0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("div0_step", 32'(step), 1);
      end

      // Reset in the middle of a one-shot.
      tick_div = 8'd3;
      wr(0, 2, 16'hFFFF);
      cnt = 0; guard = 0;
      while (cnt < 5 && guard < 100) begin
         tick();
         if (step) cnt++;
         guard++;
      end
      chk("mid_timeout", 32'(guard < 100), 1);
      chk("mid_busy_pre", 32'(busy[0]), 1);
      rst_n = 1'b0; tick();
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_led",  32'(led), 0);
      rst_n = 1'b1; tick();
      chk("mid_rel_led", 32'(led), 32'(3'b111));

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         tick_div = DIVW'($urandom_range(0, 7));
         resync   = ($urandom_range(0, 19) == 0);
         rst_n    = ($urandom_range(0, 199) != 0);
         cfg_wen  = ($urandom_range(0, 4) == 0);
         cfg_ch   = CHW'($urandom_range(0, 3));
         cfg_mode = 2'($urandom_range(0, 3));
         cfg_pat  = PLEN'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
